// File: rtl/bandscope_reader.sv
// bandscope_reader: reads a completed capture frame out of the bandscope RAM
// and streams it to the host link as packets of one header word followed by
// PKT_WORDS sample words.
module bandscope_reader #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned PKT_WORDS = 512,
    parameter logic [7:0]  HDR_TAG   = 8'hB5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bs_on,
    input  logic              bs_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    localparam int unsigned PW_LOG = $clog2(PKT_WORDS);
    localparam int unsigned PIDX_W = ADDR_W - PW_LOG;
    localparam int unsigned CNT_W  = PW_LOG + 1;
    localparam logic [CNT_W-1:0] PKT_N    = CNT_W'(PKT_WORDS);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t              state_q;
    logic                sync1_q, sync2_q, seen_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                tx_valid_q, tx_last_q, busy_q;
    logic [7:0]          overrun_q;
    logic [PIDX_W-1:0]   pkt_idx_q;
    logic [CNT_W-1:0]    rd_cnt_q, out_cnt_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   skid0_q, skid1_q, skid0_d, skid1_d;
    logic [1:0]          skid_cnt_q, skid_cnt_d;

    logic                ev, accept, out_free, last_acc, want, load, pop, push, issue;
    logic [DATA_W-1:0]   src;

    function automatic logic [DATA_W-1:0] hdr_word(input logic [PIDX_W-1:0] idx);
        logic [7:0] idx8;
        idx8 = 8'(idx);
        return DATA_W'({HDR_TAG, idx8});
    endfunction

    // Two-flop synchroniser for the asynchronous frame toggle; left unreset on purpose
    always_ff @(posedge clock) begin
        sync1_q <= bs_ready;
        sync2_q <= sync1_q;
    end

    // Last-seen toggle level tracks the synchroniser even in reset, so reset never makes an event
    always_ff @(posedge clock) begin
        seen_q <= sync2_q;
    end

    // Output-stage handshake decisions, read issue and skid-buffer next state
    always_comb begin
        ev       = sync2_q ^ seen_q;
        accept   = tx_valid_q & tx_ready;
        out_free = ~tx_valid_q | tx_ready;
        last_acc = (state_q == S_DATA) & accept & tx_last_q;
        case (state_q)
            S_HDR:   want = accept;
            S_DATA:  want = out_free & ~last_acc;
            default: want = 1'b0;
        endcase
        load  = want & ((skid_cnt_q != 2'd0) | inflight_q);
        src   = (skid_cnt_q != 2'd0) ? skid0_q : rd_data;
        pop   = load & (skid_cnt_q != 2'd0);
        // Returning RAM data bypasses the skid buffer when it goes straight to the output
        push  = inflight_q & ~(load & (skid_cnt_q == 2'd0));
        issue = (state_q != S_IDLE) & (rd_cnt_q != PKT_N) &
                ((skid_cnt_q + {1'b0, inflight_q}) < 2'd2);

        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        case ({pop, push})
            2'b10: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b01: begin
                if (skid_cnt_q == 2'd0) skid0_d = rd_data;
                else                    skid1_d = rd_data;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = rd_data;
                end
            end
            default: ;
        endcase
    end

    // Packet FSM with registered stream outputs, read pointer and overrun counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= '0;
            pkt_idx_q  <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_cnt_q <= '0;
        end else begin
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            skid_cnt_q <= skid_cnt_d;
            inflight_q <= issue;
            if (issue) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
                rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
            end
            if (ev && (state_q != S_IDLE) && (overrun_q != 8'hFF))
                overrun_q <= overrun_q + 8'd1;

            case (state_q)
                S_IDLE: begin
                    if (ev && bs_on) begin
                        state_q    <= S_HDR;
                        busy_q     <= 1'b1;
                        pkt_idx_q  <= '0;
                        rd_addr_q  <= '0;
                        rd_cnt_q   <= '0;
                        out_cnt_q  <= '0;
                        tx_data_q  <= hdr_word('0);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        state_q <= S_DATA;
                        if (load) begin
                            tx_data_q  <= src;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= (out_cnt_q == PKT_LAST);
                            out_cnt_q  <= out_cnt_q + CNT_W'(1);
                        end else begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (last_acc) begin
                        if ((pkt_idx_q == '1) || !bs_on) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                        end else begin
                            state_q    <= S_HDR;
                            pkt_idx_q  <= pkt_idx_q + PIDX_W'(1);
                            tx_data_q  <= hdr_word(pkt_idx_q + PIDX_W'(1));
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= 1'b0;
                            rd_cnt_q   <= '0;
                            out_cnt_q  <= '0;
                        end
                    end else if (out_free) begin
                        if (load) begin
                            tx_data_q  <= src;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= (out_cnt_q == PKT_LAST);
                            out_cnt_q  <= out_cnt_q + CNT_W'(1);
                        end else begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr     = rd_addr_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign busy        = busy_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_bandscope_reader.sv
// Bench for bandscope_reader: RAM model, frame-level stream model and checks.
module tb_bandscope_reader;

    localparam int AW   = 14;
    localparam int DW   = 16;
    localparam int PW   = 512;
    localparam int NPKT = 32;

    logic          clock = 1'b0;
    logic          reset, bs_on, bs_ready, tx_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, tx_data;
    logic          tx_valid, tx_last, busy;
    logic [7:0]    overrun_cnt;

    always #5 clock = ~clock;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) rd_data <= mem[rd_addr];

    bandscope_reader #(.ADDR_W(AW), .DATA_W(DW), .PKT_WORDS(PW), .HDR_TAG(8'hB5)) dut (
        .clock(clock), .reset(reset), .bs_on(bs_on), .bs_ready(bs_ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        total++;
        if (act > lim) begin
            bad++;
            $display("FAIL %s: got %0d want <= %0d at %0t", name, act, lim, $time);
        end
    endtask

    // stimulus-owned
    int  start_req = 0;
    int  exp_ovr   = 0;
    bit  rand_ready = 1'b0;

    // model-owned (compare process)
    int            start_seen = 0;
    bit            m_active = 1'b0;
    int            m_pkt = 0, m_word = 0, lat = 0;
    bit            s_pend = 1'b0, end_chk = 1'b0;
    int            s_wait = 0;
    int            hdr_count = 0, last_count = 0, word_count = 0;
    logic [DW-1:0] first_hdr = '0, last_hdr = '0;
    bit            prev_stall = 1'b0, prev_last = 1'b0, prev_busy = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;

    // tx_ready driver: always-ready or 50% random
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream model: expected words come from frame/packet arithmetic over the RAM contents
    always @(negedge clock) begin
        logic [DW-1:0] exp_d;
        logic          exp_l;
        logic [AW-1:0] nxt_addr;
        if (reset) begin
            m_active   = 1'b0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
            s_pend     = 1'b0;
            end_chk    = 1'b0;
            start_seen = start_req;
            lat        = 0;
        end else begin
            if (end_chk) begin
                chk_eq("busy_after_frame", 32'(busy), 32'd0);
                chk_eq("valid_after_frame", 32'(tx_valid), 32'd0);
                end_chk = 1'b0;
            end
            if (prev_stall) begin
                chk_eq("stall_valid", 32'(tx_valid), 32'd1);
                chk_eq("stall_data", 32'(tx_data), 32'(prev_data));
                chk_eq("stall_last", 32'(tx_last), 32'(prev_last));
            end
            if (busy && prev_busy && rd_addr != prev_addr) begin
                nxt_addr = prev_addr + 1'b1;
                chk_eq("rd_addr_step", 32'(rd_addr), 32'(nxt_addr));
            end
            if (s_pend) begin
                if (tx_valid) begin
                    chk_le("first_sample_latency", s_wait + 1, 2);
                    s_pend = 1'b0;
                end else begin
                    s_wait++;
                    if (s_wait >= 2) begin
                        chk_le("first_sample_latency", s_wait + 1, 2);
                        s_pend = 1'b0;
                    end
                end
            end
            if (tx_valid) chk_eq("busy_with_valid", 32'(busy), 32'd1);
            if (tx_valid && !m_active) begin
                if (start_req != start_seen) begin
                    chk_le("hdr_latency", lat, 3);
                    start_seen = start_req;
                    m_active = 1'b1;
                    m_pkt = 0;
                    m_word = -1;
                    lat = 0;
                    hdr_count = 0;
                    last_count = 0;
                    word_count = 0;
                end else begin
                    chk_eq("spurious_valid", 32'(tx_valid), 32'd0);
                end
            end else if (!m_active && start_req != start_seen) begin
                lat++;
                if (lat > 10) begin
                    chk_le("hdr_latency", lat, 3);
                    start_seen = start_req;
                    lat = 0;
                end
            end
            if (m_active && tx_valid && tx_ready) begin
                if (m_word < 0) begin
                    exp_d = {8'hB5, 3'b000, m_pkt[4:0]};
                    exp_l = 1'b0;
                end else begin
                    exp_d = mem[m_pkt * PW + m_word];
                    exp_l = (m_word == PW - 1);
                end
                chk_eq("tx_data", 32'(tx_data), 32'(exp_d));
                chk_eq("tx_last", 32'(tx_last), 32'(exp_l));
                if (m_word < 0) begin
                    if (hdr_count == 0) first_hdr = tx_data;
                    last_hdr = tx_data;
                    hdr_count++;
                    m_word = 0;
                    s_pend = 1'b1;
                    s_wait = 0;
                end else begin
                    word_count++;
                    if (tx_last) last_count++;
                    if (m_word == PW - 1) begin
                        if (m_pkt == NPKT - 1 || !bs_on) begin
                            m_active = 1'b0;
                            end_chk = 1'b1;
                        end else begin
                            m_pkt++;
                            m_word = -1;
                        end
                    end else begin
                        m_word++;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            prev_busy  = busy;
            prev_addr  = rd_addr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic toggle();
        bs_ready = ~bs_ready;
        if (m_active || start_req != start_seen) begin
            if (exp_ovr < 255) exp_ovr++;
        end else if (bs_on) begin
            start_req++;
        end
    endtask

    task automatic wait_pkt(input int p, input int w, input int bound, input string name);
        int n = 0;
        while (!(m_active && (m_pkt > p || (m_pkt == p && m_word >= w))) && n < bound) begin
            tick(1);
            n++;
        end
        chk_le(name, n, bound - 1);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while ((m_active || start_req != start_seen) && n < bound) begin
            tick(1);
            n++;
        end
        chk_le(name, n, bound - 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk_eq({tag, "_tx_last"}, 32'(tx_last), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        bs_on = 1'b1;
        bs_ready = 1'b0;
        tick(5);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(5);

        // Full frame, always ready
        toggle();
        wait_idle(20000, "frameA_timeout");
        tick(3);
        chk_eq("A_headers", 32'(hdr_count), 32'd32);
        chk_eq("A_last_pulses", 32'(last_count), 32'd32);
        chk_eq("A_samples", 32'(word_count), 32'd16384);
        chk_eq("A_first_hdr", 32'(first_hdr), 32'hB500);
        chk_eq("A_last_hdr", 32'(last_hdr), 32'hB51F);
        chk_eq("A_rd_addr_wrapped", 32'(rd_addr), 32'd0);
        chk_eq("A_busy", 32'(busy), 32'd0);
        chk_eq("A_overrun", 32'(overrun_cnt), 32'd0);

        // Full frame with random stalls and a second toggle during packet 5
        rand_ready = 1'b1;
        toggle();
        wait_pkt(5, 10, 12000, "reach_pkt5_timeout");
        toggle();
        wait_idle(45000, "frameB_timeout");
        rand_ready = 1'b0;
        tick(5);
        chk_eq("B_headers", 32'(hdr_count), 32'd32);
        chk_eq("B_samples", 32'(word_count), 32'd16384);
        chk_eq("B_overrun_model", 32'(overrun_cnt), 32'(exp_ovr));
        chk_eq("B_overrun", 32'(overrun_cnt), 32'd1);
        chk_eq("B_busy", 32'(busy), 32'd0);

        // bs_on drops at word 100 of packet 3
        toggle();
        wait_pkt(3, 100, 6000, "reach_pkt3_timeout");
        bs_on = 1'b0;
        wait_idle(3000, "frameC_timeout");
        tick(5);
        chk_eq("C_last_hdr", 32'(last_hdr), 32'hB503);
        chk_eq("C_headers", 32'(hdr_count), 32'd4);
        chk_eq("C_last_pulses", 32'(last_count), 32'd4);
        chk_eq("C_busy", 32'(busy), 32'd0);
        chk_eq("C_valid", 32'(tx_valid), 32'd0);

        // Toggle while idle and disabled is ignored
        toggle();
        tick(20);
        chk_eq("ignored_overrun", 32'(overrun_cnt), 32'(exp_ovr));
        chk_eq("ignored_busy", 32'(busy), 32'd0);
        bs_on = 1'b1;
        tick(5);

        // Saturating overrun, then reset mid-frame with bs_ready held high
        toggle();
        wait_pkt(0, -1, 20, "frameD_start_timeout");
        for (int k = 0; k < 301; k++) begin
            tick(4);
            toggle();
        end
        tick(10);
        chk_eq("D_overrun_sat", 32'(overrun_cnt), 32'hFF);
        chk_eq("D_overrun_model", 32'(overrun_cnt), 32'(exp_ovr));
        wait_pkt(10, 50, 15000, "reach_pkt10_timeout");
        chk_eq("D_bs_ready_high", 32'(bs_ready), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_all_zero("reset_mid");
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(100);
        chk_eq("post_reset_valid", 32'(tx_valid), 32'd0);
        chk_eq("post_reset_busy", 32'(busy), 32'd0);
        chk_eq("post_reset_rd_addr", 32'(rd_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
